// File: rtl/upower_ctrl_pkg.sv
// Shared types and constants for the uPOWER multi-cycle control.
// Opcode/XO values, ALU encodings, FSM states and trap causes.
package upower_ctrl_pkg;

   localparam logic [5:0] OP_ADDI = 6'd14;
   localparam logic [5:0] OP_ORI  = 6'd24;
   localparam logic [5:0] OP_ANDI = 6'd28;
   localparam logic [5:0] OP_X31  = 6'd31;
   localparam logic [5:0] OP_LD   = 6'd58;
   localparam logic [5:0] OP_STD  = 6'd62;

   localparam logic [9:0] XO_AND  = 10'd28;
   localparam logic [9:0] XO_SUBF = 10'd40;
   localparam logic [9:0] XO_ADD  = 10'd266;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam logic [1:0] TC_NONE    = 2'b00;
   localparam logic [1:0] TC_ILLEGAL = 2'b01;
   localparam logic [1:0] TC_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef enum logic [1:0] {
      C_ALU, C_LD, C_STD
   } iclass_t;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       reg_dst;
      logic       reg1;
      logic       reg2;
      logic       mem_to_reg;
   } ctl_t;

   typedef struct packed {
      iclass_t cls;
      logic    legal;
      ctl_t    ctl;
   } dec_t;

   function automatic ctl_t mk_ctl(
      input logic [3:0] op,
      input logic       src,
      input logic       dst,
      input logic       r1,
      input logic       r2,
      input logic       m2r
   );
      ctl_t c;
      c.alu_op     = op;
      c.alu_src    = src;
      c.reg_dst    = dst;
      c.reg1       = r1;
      c.reg2       = r2;
      c.mem_to_reg = m2r;
      return c;
   endfunction

endpackage

// File: rtl/upower_decode.sv
// Combinational uPOWER decoder: opcode, XO and DS bits in,
// instruction class, legality and datapath control fields out.
import upower_ctrl_pkg::*;

module upower_decode (
   input  logic [5:0] opcd,
   input  logic [9:0] xo,
   input  logic [1:0] ds,
   output dec_t       dec
);

   always_comb begin
      dec = '0;
      unique case (1'b1)
         (opcd == OP_ADDI): begin
            dec.legal = 1'b1;
            dec.ctl   = mk_ctl(ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         end
         (opcd == OP_ANDI): begin
            dec.legal = 1'b1;
            dec.ctl   = mk_ctl(ALU_AND, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         (opcd == OP_ORI): begin
            dec.legal = 1'b1;
            dec.ctl   = mk_ctl(ALU_OR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         (opcd == OP_X31): begin
            unique case (1'b1)
               (xo == XO_ADD): begin
                  dec.legal = 1'b1;
                  dec.ctl   = mk_ctl(ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
               end
               (xo == XO_SUBF): begin
                  dec.legal = 1'b1;
                  dec.ctl   = mk_ctl(ALU_SUB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
               end
               (xo == XO_AND): begin
                  dec.legal = 1'b1;
                  dec.ctl   = mk_ctl(ALU_AND, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
               end
               default: ;
            endcase
         end
         // DS-form: low two bits select variants we do not implement
         (opcd == OP_LD): begin
            if (ds == 2'b00) begin
               dec.legal = 1'b1;
               dec.cls   = C_LD;
               dec.ctl   = mk_ctl(ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            end
         end
         (opcd == OP_STD): begin
            if (ds == 2'b00) begin
               dec.legal = 1'b1;
               dec.cls   = C_STD;
               dec.ctl   = mk_ctl(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/upower_multicycle_ctrl.sv
// Multi-cycle uPOWER control sequencer: IDLE/DECODE/EXEC/MEM/WB/TRAP.
// Ports: instr handshake, mem_ack, trap_clr in; IR, strobes, status out.
import upower_ctrl_pkg::*;

module upower_multicycle_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr_in,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic             mem_ack,
   input  logic             trap_clr,
   output logic [31:0]      instruction,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             ALUSrc,
   output logic             RegDst,
   output logic             reg1,
   output logic             reg2,
   output logic [3:0]       ALU_OP,
   output logic             done,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] retired
);

   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   iclass_t    cls;
   ctl_t       ctl;
   logic [7:0] tcnt;
   dec_t       dec;

   upower_decode u_dec (
      .opcd (instruction[31:26]),
      .xo   (instruction[10:1]),
      .ds   (instruction[1:0]),
      .dec  (dec)
   );

   assign instr_ready = (state == S_IDLE);
   assign ALU_OP      = ctl.alu_op;
   assign ALUSrc      = ctl.alu_src;
   assign RegDst      = ctl.reg_dst;
   assign reg1        = ctl.reg1;
   assign reg2        = ctl.reg2;
   assign MemtoReg    = ctl.mem_to_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         cls         <= C_ALU;
         ctl         <= '0;
         tcnt        <= '0;
         instruction <= '0;
         RegWrite    <= 1'b0;
         MemRead     <= 1'b0;
         MemWrite    <= 1'b0;
         done        <= 1'b0;
         trap        <= 1'b0;
         trap_cause  <= TC_NONE;
         retired     <= '0;
      end else begin
         done     <= 1'b0;
         RegWrite <= 1'b0;
         MemRead  <= 1'b0;
         MemWrite <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  instruction <= instr_in;
                  state       <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (dec.legal) begin
                  state <= S_EXEC;
                  cls   <= dec.cls;
                  ctl   <= dec.ctl;
               end else begin
                  state      <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= TC_ILLEGAL;
               end
            end
            S_EXEC: begin
               if (cls == C_ALU) begin
                  state    <= S_WB;
                  RegWrite <= 1'b1;
               end else begin
                  state    <= S_MEM;
                  tcnt     <= '0;
                  MemRead  <= (cls == C_LD);
                  MemWrite <= (cls == C_STD);
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  if (cls == C_LD) begin
                     state    <= S_WB;
                     RegWrite <= 1'b1;
                  end else begin
                     state   <= S_IDLE;
                     done    <= 1'b1;
                     retired <= retired + CNT_W'(1);
                     ctl     <= '0;
                  end
               end else if (tcnt == TMO_LAST) begin
                  state      <= S_TRAP;
                  trap       <= 1'b1;
                  trap_cause <= TC_TIMEOUT;
                  ctl        <= '0;
               end else begin
                  tcnt     <= tcnt + 8'd1;
                  MemRead  <= MemRead;
                  MemWrite <= MemWrite;
               end
            end
            S_WB: begin
               state   <= S_IDLE;
               done    <= 1'b1;
               retired <= retired + CNT_W'(1);
               ctl     <= '0;
            end
            S_TRAP: begin
               if (trap_clr) begin
                  state      <= S_IDLE;
                  trap       <= 1'b0;
                  trap_cause <= TC_NONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
